// File: rtl/imem_loader_if.sv
// imem_loader_if: UART byte streams and IMEM port A write bus of the program loader.
// master = loader side, slave = UART/IMEM side.
interface imem_loader_if #(
    parameter int AW = 14
);
    logic [7:0]    data_in;
    logic          data_in_valid;
    logic          data_in_ready;
    logic [7:0]    data_out;
    logic          data_out_valid;
    logic          data_out_ready;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_din;
    logic [3:0]    imem_we;

    modport master (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid, imem_addr, imem_din, imem_we
    );

    modport slave (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid, imem_addr, imem_din, imem_we
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: loads IMEM from UART frames (A5, addr, len, words[, csum]) and answers ACK/NAK.
// Define IMEM_LOADER_CHECKSUM_EN to add and verify the trailing mod-256 checksum byte.
module imem_loader #(
    parameter int IMEM_AWIDTH    = 14,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_loader_if.master bus,
    output logic          busy_o,
    output logic          load_done_o,
    output logic          load_err_o
);
    typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM, RESP} state_e;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] SYNC = 8'hA5;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    state_e                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [31:0]            sh_q, sh_d;
    logic [15:0]            rem_q, rem_d;
    logic [IMEM_AWIDTH-1:0] wptr_q, wptr_d, iaddr_q, iaddr_d;
    logic [31:0]            din_q, din_d;
    logic                   we_q, we_d;
    logic                   bad_q, bad_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [7:0]             dout_q, dout_d;
    logic                   dvld_q, dvld_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   acc, tmo_hit, fin, resp, ok;
    logic [31:0]            nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]             sum_q, sum_d;
`endif

    assign bus.data_in_ready  = state_q != RESP;
    assign bus.data_out       = dout_q;
    assign bus.data_out_valid = dvld_q;
    assign bus.imem_addr      = iaddr_q;
    assign bus.imem_din       = din_q;
    assign bus.imem_we        = {4{we_q}};
    assign busy_o             = state_q != IDLE;
    assign load_done_o        = done_q;
    assign load_err_o         = err_q;

    always_comb begin
        acc     = bus.data_in_valid && bus.data_in_ready;
        nxt     = {bus.data_in, sh_q[31:8]};
        tmo_hit = (state_q inside {ADDR, LEN, DATA, CSUM}) && tmo_q == TW'(TIMEOUT_CYCLES);
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        rem_d   = rem_q;
        wptr_d  = wptr_q;
        iaddr_d = iaddr_q;
        din_d   = din_q;
        we_d    = 1'b0;
        bad_d   = bad_q;
        tmo_d   = '0;
        dout_d  = dout_q;
        dvld_d  = dvld_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        fin     = 1'b0;
        resp    = 1'b0;
        ok      = !bad_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = acc ? sum_q + bus.data_in : sum_q;
`endif
        if (state_q inside {ADDR, LEN, DATA, CSUM})
            tmo_d = acc ? '0 : tmo_q + 1'b1;
        if (acc) begin
            cnt_d = cnt_q + 2'd1;
            sh_d  = nxt;
        end
        // a timed-out frame drops straight into IDLE handling, including any byte arriving now
        if (tmo_hit || state_q == IDLE) begin
            err_d   = tmo_hit;
            cnt_d   = '0;
            tmo_d   = '0;
            bad_d   = 1'b0;
            state_d = (acc && bus.data_in == SYNC) ? ADDR : IDLE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
        end else begin
            case (state_q)
                ADDR: if (acc && cnt_q == 2'd3) begin
                    state_d = LEN;
                    bad_d   = nxt[31:28] != 4'b0001 || nxt[1:0] != 2'b00;
                    wptr_d  = nxt[IMEM_AWIDTH+1:2];
                end
                LEN: if (acc && cnt_q == 2'd1) begin
                    cnt_d   = '0;
                    rem_d   = nxt[31:16];
                    fin     = nxt[31:16] == 16'd0;
                    state_d = DATA;
                end
                DATA: if (acc && cnt_q == 2'd3) begin
                    we_d    = !bad_q;
                    iaddr_d = wptr_q;
                    din_d   = nxt;
                    wptr_d  = wptr_q + 1'b1;
                    rem_d   = rem_q - 16'd1;
                    fin     = rem_q == 16'd1;
                    if (&wptr_q && rem_q != 16'd1)
                        bad_d = 1'b1;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: if (acc) begin
                    resp = 1'b1;
                    ok   = !bad_q && sum_q == bus.data_in;
                end
`endif
                RESP: if (bus.data_out_ready) begin
                    dvld_d  = 1'b0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (fin)
            state_d = CSUM;
`else
        if (fin)
            resp = 1'b1;
`endif
        if (resp) begin
            state_d = RESP;
            dvld_d  = 1'b1;
            dout_d  = ok ? ACK : NAK;
            done_d  = ok;
            err_d   = !ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            rem_q   <= '0;
            wptr_q  <= '0;
            iaddr_q <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            tmo_q   <= '0;
            dout_q  <= '0;
            dvld_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            rem_q   <= rem_d;
            wptr_q  <= wptr_d;
            iaddr_q <= iaddr_d;
            din_q   <= din_d;
            we_q    <= we_d;
            bad_q   <= bad_d;
            tmo_q   <= tmo_d;
            dout_q  <= dout_d;
            dvld_q  <= dvld_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end
endmodule
